mem_bist_initiator: RTL and testbench
=====================================

# mem_bist_initiator

Initiator-side controller for the single-port memory's valid/ready/wr_rd bus. On a `start` pulse it runs a four-phase write/read-compare test over every address:

- write a seed-derived pattern, then read it back and compare;
- write the complemented pattern, then read it back and compare.

It reports pass/fail, the mismatch count, the first failing address and a timeout flag. It sits between a test/control register block and the memory's port, and is the master the memory responds to.

## Interface
- `WIDTH`, default 8: data width; must match the memory.
- `DEPTH`, default 16: number of words tested (addresses 0..DEPTH-1).
- `ADDR_WIDTH`, default $clog2(DEPTH): address width.
- `TIMEOUT`, default 15: maximum WAIT cycles without `m_ready` before abort; must be ≥1.

Ports:
- `clk`, in, 1: clock; all logic on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: begin test; sampled only in IDLE.
- `seed`, in, WIDTH: pattern seed; captured on the accepted `start`.
- `busy`, out, 1: high from the accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse at test end.
- `pass`, out, 1: valid from `done` and held until the next accepted `start`; 1 only if `err_count`==0 and `timeout_err`==0.
- `err_count`, out, ADDR_WIDTH+2: number of read mismatches (max 2*DEPTH, no wrap).
- `first_err_addr`, out, ADDR_WIDTH: address of the first mismatch; 0 if none.
- `timeout_err`, out, 1: set when a timeout aborts the test.
- `m_valid`, out, 1: request valid to memory.
- `m_wr_rd`, out, 1: 1 = write, 0 = read.
- `m_addr`, out, ADDR_WIDTH: request address.
- `m_wdata`, out, WIDTH: write data; 0 on reads.
- `m_ready`, in, 1: memory response. A registered response to `m_valid` sampled on the previous edge.
- `m_rdata`, in, WIDTH: read data; meaningful only when `m_ready`=1 for a read.

## Operation
- **Registers:** every output is registered.
  - On `rst`: all outputs 0, FSM to IDLE, and internal phase, address, timeout and seed registers cleared.
- **FSM states:** IDLE, ISSUE, WAIT, FIN.
  - **IDLE → ISSUE** when `start`=1. On that edge:
    - capture `seed`;
    - clear `err_count`, `first_err_addr`, `timeout_err` and `pass`;
    - phase=0, addr=0;
    - set `busy`=1 and `m_valid`=1.
  - **ISSUE:** `m_valid`=1 for exactly one cycle, with `m_wr_rd`/`m_addr`/`m_wdata` per the current phase. Always → WAIT.
  - **WAIT:** `m_valid`=0 and the other request outputs are held.
    - If `m_ready`=1 and the access is a read, compare `m_rdata` with the expected pattern. On mismatch:
      - `err_count`+1;
      - if this is the first mismatch, latch `first_err_addr`.
    - Then advance: addr+1. At addr=DEPTH-1, wrap addr to 0 and phase+1.
    - After the access at phase=3, addr=DEPTH-1: → FIN; otherwise → ISSUE.
    - If `m_ready`=0 for TIMEOUT consecutive WAIT cycles: set `timeout_err`=1 → FIN.
  - **FIN:** `done`=1 for one cycle, `busy`=0, `pass` updated → IDLE.
- **Pattern:** P(a) = (seed + a) mod 2^WIDTH, with `a` zero-extended.

| Phase | Access | Data |
|---|---|---|
| 0 | write | P(a) |
| 1 | read | expect P(a) |
| 2 | write | ~P(a) |
| 3 | read | expect ~P(a) |

- **Start while busy:** `start` in any state other than IDLE is ignored.
- **Write responses:** `m_rdata` is ignored on writes.
- **Result hold:** `err_count`, `first_err_addr`, `timeout_err` and `pass` hold their values after FIN until the next accepted `start` or `rst`.

## Timing
- **Access slots:** `start` is accepted at edge T0. Access k (0..4*DEPTH-1) has its ISSUE cycle beginning at T0+2k and its WAIT cycle at T0+2k+1, given a memory that responds one cycle after `m_valid`.
- **Normal completion:** `done` pulses in the cycle beginning at T0+8*DEPTH (128 cycles for DEPTH=16). `busy` is low from that same edge.
- **Timeout completion:** `done` follows TIMEOUT WAIT cycles after the stalled access's ISSUE cycle, plus one cycle in FIN. `m_valid` stays 0 throughout.
- **Reset mid-operation:** at the `rst` edge all outputs go to 0, including `m_valid`, `busy` and `done`. The partial result is discarded and the FSM is in IDLE on the next cycle.
- **Extra `m_ready`:** `m_ready`=1 outside WAIT is ignored.

## Test plan
- **Clean run:** real 16x8 memory, seed=8'hA5, one-cycle `start`. Required: 32 writes of 0xA5..0xB4 then 0x5A..0x4B; `done` exactly 128 cycles after `start`; `pass`=1, `err_count`=0, `first_err_addr`=0.
- **Stuck-at bit:** memory model with addr 5 bit0 stuck at 0, seed=8'h00. Required: phase 1 reads 0x04 where 0x05 is expected; phase 3 matches (0xFA); `err_count`=1, `first_err_addr`=5, `pass`=0.
- **Timeout:** `m_ready` tied 0, TIMEOUT=15. Required: first write issued to addr 0; `done` 16 cycles after the ISSUE cycle; `timeout_err`=1, `pass`=0, `busy`=0.
- **Start while busy:** `start` pulsed at cycles 10 and 50 after the first accepted `start`. Required: a single 128-cycle run and one `done` pulse.
- **Reset mid-run:** assert `rst` during access 20. Required: all outputs 0 on the next cycle. A following `start` with seed=8'h3C completes with `pass`=1.
- **Pattern wrap:** seed=8'hF8. Required: addresses 8..15 are written with 0x00..0x07 and 0xFF..0xF8 respectively, and the run ends with `pass`=1.

Source files
------------

// File: rtl/mem_bist_initiator.sv
// ---------------------------------------------------------------------------
// mem_bist_initiator : four-phase write/read-compare BIST master  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module mem_bist_initiator #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH+1:0] err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  timeout_err,
  output logic                  m_valid,
  output logic                  m_wr_rd,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0]      m_wdata,
  input  logic                  m_ready,
  input  logic [WIDTH-1:0]      m_rdata
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]            state, state_n;
  logic [1:0]            phase, phase_n;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [TW-1:0]         tcnt, tcnt_n;
  logic [WIDTH-1:0]      seed_q, seed_n;

  logic                  busy_n, done_n, pass_n, to_n;
  logic [ADDR_WIDTH+1:0] err_n;
  logic [ADDR_WIDTH-1:0] fea_n, maddr_n;
  logic                  valid_n, wr_rd_n;
  logic [WIDTH-1:0]      wdata_n;
  logic                  mismatch;

  logic last_access, addr_last, timed_out;

  assign addr_last   = (addr == ADDR_WIDTH'(DEPTH - 1));
  assign last_access = (phase == 2'd3) && addr_last;
  assign timed_out   = !m_ready && (tcnt == TW'(TIMEOUT - 1));

  // Write data for a given phase/address; reads drive zero
  function automatic logic [WIDTH-1:0] wr_pattern(input logic [1:0] ph,
                                                  input logic [ADDR_WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] p;
    p = s + WIDTH'(a);
    case (ph)
      2'd0:    wr_pattern = p;
      2'd2:    wr_pattern = ~p;
      default: wr_pattern = '0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] rd_expect(input logic [1:0] ph,
                                                 input logic [ADDR_WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] p;
    p = s + WIDTH'(a);
    rd_expect = (ph == 2'd3) ? ~p : p;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_ISSUE;
      S_ISSUE: state_n = S_WAIT;
      S_WAIT: begin
        if (m_ready)        state_n = last_access ? S_FIN : S_ISSUE;
        else if (timed_out) state_n = S_FIN;
      end
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Next values of every registered output and datapath register
  always_comb begin
    seed_n   = seed_q;
    phase_n  = phase;
    addr_n   = addr;
    tcnt_n   = tcnt;
    busy_n   = busy;
    done_n   = 1'b0;
    pass_n   = pass;
    err_n    = err_count;
    fea_n    = first_err_addr;
    to_n     = timeout_err;
    valid_n  = 1'b0;
    wr_rd_n  = m_wr_rd;
    maddr_n  = m_addr;
    wdata_n  = m_wdata;
    mismatch = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          seed_n  = seed;
          err_n   = '0;
          fea_n   = '0;
          to_n    = 1'b0;
          pass_n  = 1'b0;
          phase_n = 2'd0;
          addr_n  = '0;
          busy_n  = 1'b1;
          valid_n = 1'b1;
          wr_rd_n = 1'b1;
          maddr_n = '0;
          wdata_n = seed;
        end
      end
      S_ISSUE: tcnt_n = '0;
      S_WAIT: begin
        if (m_ready) begin
          mismatch = phase[0] && (m_rdata != rd_expect(phase, addr, seed_q));
          if (mismatch) begin
            err_n = err_count + 1'b1;
            if (err_count == '0) fea_n = addr;
          end
          if (last_access) begin
            busy_n = 1'b0;
            done_n = 1'b1;
            pass_n = (err_n == '0) && !timeout_err;
          end else begin
            if (addr_last) begin
              addr_n  = '0;
              phase_n = phase + 2'd1;
            end else begin
              addr_n  = addr + 1'b1;
            end
            valid_n = 1'b1;
            wr_rd_n = ~phase_n[0];
            maddr_n = addr_n;
            wdata_n = wr_pattern(phase_n, addr_n, seed_q);
          end
        end else if (timed_out) begin
          to_n   = 1'b1;
          busy_n = 1'b0;
          done_n = 1'b1;
          pass_n = 1'b0;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seed_q         <= '0;
      phase          <= '0;
      addr           <= '0;
      tcnt           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      timeout_err    <= 1'b0;
      m_valid        <= 1'b0;
      m_wr_rd        <= 1'b0;
      m_addr         <= '0;
      m_wdata        <= '0;
    end else begin
      seed_q         <= seed_n;
      phase          <= phase_n;
      addr           <= addr_n;
      tcnt           <= tcnt_n;
      busy           <= busy_n;
      done           <= done_n;
      pass           <= pass_n;
      err_count      <= err_n;
      first_err_addr <= fea_n;
      timeout_err    <= to_n;
      m_valid        <= valid_n;
      m_wr_rd        <= wr_rd_n;
      m_addr         <= maddr_n;
      m_wdata        <= wdata_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_bist_initiator.sv
// ---------------------------------------------------------------------------
// tb_mem_bist_initiator : scoreboard bench with a 16x8 memory model  (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_bist_initiator;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam int RW = 1 + AW + W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  seed_in = '0;
  logic          busy, done, pass, timeout_err;
  logic [AW+1:0] err_count;
  logic [AW-1:0] first_err_addr;
  logic          m_valid, m_wr_rd;
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_wdata;
  logic          m_ready;
  logic [W-1:0]  m_rdata;

  mem_bist_initiator #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .timeout_err(timeout_err),
    .m_valid(m_valid), .m_wr_rd(m_wr_rd), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int done_cnt = 0, done_cyc = 0, issue_cyc = 0;

  // Memory model: registered response one cycle after m_valid
  logic         ready_en = 1'b1;
  logic         stuck    = 1'b0;
  logic [W-1:0] mem [D];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_ready <= 1'b0;
      m_rdata <= '0;
    end else begin
      m_ready <= m_valid && ready_en;
      if (m_valid) begin
        if (m_wr_rd) mem[m_addr] <= m_wdata;
        else m_rdata <= (stuck && m_addr == 4'd5) ? (mem[m_addr] & 8'hFE) : mem[m_addr];
      end
    end
  end

  logic [RW-1:0] exp_q[$];

  // Scoreboard: every request the DUT issues is checked against the queue
  always @(negedge clk) begin
    if (!rst && m_valid) begin
      issue_cyc = cyc;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL req_unexpected: got wr=%0b addr=%0d data=%h, required none", m_wr_rd, m_addr, m_wdata);
      end else begin
        logic [RW-1:0] e;
        e = exp_q.pop_front();
        if ({m_wr_rd, m_addr, m_wdata} !== e) begin
          n_fail++;
          $display("FAIL req: got wr=%0b addr=%0d data=%h, required wr=%0b addr=%0d data=%h",
                   m_wr_rd, m_addr, m_wdata, e[RW-1], e[RW-2 -: AW], e[W-1:0]);
        end
      end
    end
    if (!rst && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  int t0;

  // Drives one start pulse and queues the first n expected requests
  task automatic start_run(input logic [W-1:0] s, input int n);
    for (int k = 0; k < n; k++) begin
      int ph, a;
      logic [W-1:0] p, d;
      ph = k / D;
      a  = k % D;
      p  = s + W'(a);
      d  = (ph == 0) ? p : (ph == 2) ? ~p : '0;
      exp_q.push_back({(ph % 2 == 0), AW'(a), d});
    end
    @(negedge clk);
    start   = 1'b1;
    seed_in = s;
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0);
    for (int i = 0; i < 400 && done_cnt == n0; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [27:0] v;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    v = {busy, done, pass, err_count, first_err_addr, timeout_err, m_valid, m_wr_rd, m_addr, m_wdata};
    n_cmp++;
    if (v !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h, required 0", v); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_pass_result(input string tag, input int n0);
    n_cmp++;
    if (done_cnt != n0 + 1) begin n_fail++; $display("FAIL %s_done: got %0d pulses, required 1", tag, done_cnt - n0); end
    n_cmp++;
    if (done_cyc - t0 != 8 * D) begin n_fail++; $display("FAIL %s_latency: got %0d, required %0d", tag, done_cyc - t0, 8 * D); end
    n_cmp++;
    if ({pass, err_count, first_err_addr, timeout_err, busy} !== {1'b1, 6'd0, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL %s_result: got pass=%0b err=%0d fea=%0d to=%0b busy=%0b, required 1 0 0 0 0",
               tag, pass, err_count, first_err_addr, timeout_err, busy);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL %s_missing_reqs: got %0d left, required 0", tag, exp_q.size()); end
  endtask

  task automatic test_clean;
    int n0 = done_cnt;
    start_run(8'hA5, 4 * D);
    n_cmp++;
    if ({busy, m_valid} !== 2'b11) begin n_fail++; $display("FAIL clean_start: got busy/valid=%b, required 11", {busy, m_valid}); end
    wait_done(n0);
    @(negedge clk);
    check_pass_result("clean", n0);
  endtask

  task automatic test_stuck;
    int n0 = done_cnt;
    stuck = 1'b1;
    start_run(8'h00, 4 * D);
    wait_done(n0);
    @(negedge clk);
    n_cmp++;
    if ({err_count, first_err_addr, pass, timeout_err} !== {6'd1, 4'd5, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL stuck_result: got err=%0d fea=%0d pass=%0b to=%0b, required 1 5 0 0",
               err_count, first_err_addr, pass, timeout_err);
    end
    stuck = 1'b0;
  endtask

  task automatic test_timeout;
    int n0 = done_cnt;
    ready_en = 1'b0;
    start_run(8'h11, 1);
    wait_done(n0);
    @(negedge clk);
    n_cmp++;
    if (done_cyc - issue_cyc != 16) begin n_fail++; $display("FAIL timeout_latency: got %0d, required 16", done_cyc - issue_cyc); end
    n_cmp++;
    if ({timeout_err, pass, busy} !== 3'b100) begin
      n_fail++; $display("FAIL timeout_flags: got to/pass/busy=%b, required 100", {timeout_err, pass, busy});
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL timeout_first_req: got %0d left, required 0", exp_q.size()); end
    ready_en = 1'b1;
  endtask

  task automatic test_start_while_busy;
    int n0 = done_cnt;
    start_run(8'h42, 4 * D);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      start = (cyc == t0 + 10 || cyc == t0 + 50);
    end
    start = 1'b0;
    wait_done(n0);
    repeat (20) @(negedge clk);
    check_pass_result("busy_start", n0);
  endtask

  task automatic test_reset_mid;
    logic [27:0] v;
    int n0;
    start_run(8'h77, 4 * D);
    for (int i = 0; i < 100 && exp_q.size() > 4 * D - 21; i++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    v = {busy, done, pass, err_count, first_err_addr, timeout_err, m_valid, m_wr_rd, m_addr, m_wdata};
    n_cmp++;
    if (v !== '0) begin n_fail++; $display("FAIL midreset_outputs: got %h, required 0", v); end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    n0 = done_cnt;
    start_run(8'h3C, 4 * D);
    wait_done(n0);
    @(negedge clk);
    check_pass_result("after_reset", n0);
  endtask

  task automatic test_wrap;
    int n0 = done_cnt;
    start_run(8'hF8, 4 * D);
    wait_done(n0);
    @(negedge clk);
    check_pass_result("wrap", n0);
    n_cmp++;
    if (mem[8] !== 8'hFF || mem[15] !== 8'hF8) begin
      n_fail++; $display("FAIL wrap_mem: got m8=%h m15=%h, required FF F8", mem[8], mem[15]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean();
    test_stuck();
    test_timeout();
    test_start_while_busy();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
